fib_bcd_converter: RTL and testbench
====================================

FIB_BCD_CONVERTER -- requirements
Module: fib_bcd_converter

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter: WIDTH, default 8, binary input width (matches the Fibonacci generator output width).
REQ-003 Parameter: DIGITS, default 3, number of BCD output digits; only configurations with 10^DIGITS > 2^WIDTH-1 SHALL be supported.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-006 bin_in  input  WIDTH  unsigned binary value from the Fibonacci generator.
REQ-007 start  input  1  request to convert bin_in; sampled only on a rising edge where ready=1.
REQ-008 ready  output  1  high when the block can accept start.
REQ-009 valid  output  1  single-cycle pulse marking a new bcd_out result.
REQ-010 bcd_out  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0].

Function
REQ-011 Conversion SHALL use sequential shift-add-3 (double dabble), one binary bit per clock.
REQ-012 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-013 IDLE: ready=1, valid=0; on an edge with start=1, bin_in SHALL be loaded into a WIDTH-bit shift register, the BCD scratch register cleared, the bit counter cleared, and the state SHALL move to SHIFT.
REQ-014 IDLE with start=0 SHALL remain in IDLE.
REQ-015 SHIFT: ready=0, valid=0; each edge SHALL add 3 to every scratch digit >= 5, then shift {scratch, shift register} left by one bit and increment the counter.
REQ-016 After the WIDTH-th shift edge, bcd_out SHALL be loaded with the final scratch value on that same edge, and the state SHALL move to DONE.
REQ-017 DONE: valid=1, ready=0 for exactly one cycle; the next edge SHALL return the state to IDLE unconditionally.
REQ-018 Latency: valid SHALL be high in the cycle following the WIDTH-th edge after the edge that sampled start (default WIDTH=8: 8 edges).
REQ-019 Maximum throughput SHALL be one conversion per WIDTH+2 cycles.
REQ-020 start while ready=0 (SHIFT or DONE) SHALL be ignored, not queued, and SHALL NOT disturb the conversion in progress.
REQ-021 bin_in changes after the capture edge SHALL NOT affect the result.
REQ-022 bcd_out SHALL hold its last value until the next completion; it SHALL NOT expose intermediate scratch values.
REQ-023 start held continuously high SHALL re-capture bin_in on each IDLE edge, giving back-to-back conversions.
REQ-024 Each output digit SHALL be in the range 0..9; unused leading digits SHALL be 0.

Reset
REQ-025 With reset=0: state=IDLE, ready=1, valid=0, bcd_out=0, scratch, shift register and counter=0, all asynchronously.
REQ-026 Reset asserted mid-conversion SHALL abort it, with no valid pulse and bcd_out=0.
REQ-027 After reset deasserts, the first edge with start=1 SHALL begin a fresh conversion.

Verification
REQ-028 bin_in=0, start pulse -> after 8 edges valid=1 for 1 cycle, bcd_out=12'h000; ready high the following cycle.
REQ-029 bin_in=55 (fib(10)) -> bcd_out=12'h055; bin_in=233 (fib(13)) -> bcd_out=12'h233.
REQ-030 bin_in=255 -> bcd_out=12'h255. Sweep bin_in 0..255 and compare against a decimal reference model: all 256 must match.
REQ-031 Start with bin_in=89, then pulse start with bin_in=13 during SHIFT and during DONE -> only one valid pulse, bcd_out=12'h089.
REQ-032 Assert reset at the 4th SHIFT edge of a 144 conversion -> immediately ready=1, valid=0, bcd_out=0; no later valid until a new start is applied.
REQ-033 Hold start=1 with bin_in=21, then 34 -> valid pulses spaced 10 cycles apart; each bcd_out equals the bin_in sampled at its own capture edge.

Source files
------------

// File: rtl/fib_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one binary bit per clock.
// Latency WIDTH+1 edges start-to-valid; start is ignored while busy (ready=0).
module fib_bcd_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      bin_in,
    input  logic                  start,
    output logic                  ready,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WIDTH-1:0]    shift_reg;
    logic [4*DIGITS-1:0] scratch;
    logic [4*DIGITS-1:0] adjusted;
    logic [4*DIGITS-1:0] scratch_next;
    logic [CW-1:0]       count;
    logic                last_shift;

    assign last_shift = (count == CW'(WIDTH - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        valid = 1'b0;
        case (state)
            IDLE:    ready = 1'b1;
            DONE:    valid = 1'b1;
            default: ;
        endcase
    end

    // Add-3 correction on every digit >= 5, then shift in the next binary MSB.
    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        scratch_next = {adjusted[4*DIGITS-2:0], shift_reg[WIDTH-1]};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            scratch   <= '0;
            count     <= '0;
            bcd_out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= bin_in;
                        scratch   <= '0;
                        count     <= '0;
                    end
                end
                SHIFT: begin
                    shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                    scratch   <= scratch_next;
                    count     <= count + 1'b1;
                    if (last_shift) begin
                        bcd_out <= scratch_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_bcd_converter.sv
// Scoreboard bench for fib_bcd_converter: stimulus pushes expected BCD, a monitor pops on valid.
module tb_fib_bcd_converter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  bin_in = '0;
    logic        start = 1'b0;
    logic        ready;
    logic        valid;
    logic [11:0] bcd_out;

    fib_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
        .clock   (clock),
        .reset   (reset),
        .bin_in  (bin_in),
        .start   (start),
        .ready   (ready),
        .valid   (valid),
        .bcd_out (bcd_out)
    );

    always #5 clock = ~clock;

    logic [11:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_count = 0;
    int last_valid_cyc = 0;
    int prev_valid_cyc = 0;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (reset && valid) begin
            logic [11:0] e;
            valid_count++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: bcd_out=%h with no result expected", bcd_out);
            end else begin
                e = exp_q.pop_front();
                if (bcd_out !== e) begin
                    errors++;
                    $display("FAIL bcd_out: got %h expected %h", bcd_out, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Wait (bounded) at posedges until the monitor has counted more valids than n0.
    task automatic wait_valid(input int n0, input string name);
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clock);
            if (valid_count > n0) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout: no valid within 40 cycles (got 0 expected 1)", name);
        end
    endtask

    task automatic convert(input logic [7:0] v, input logic [11:0] e, input string name);
        int n0;
        @(negedge clock);
        check({name, "_ready_before"}, 32'(ready), 32'd1);
        bin_in = v;
        start  = 1'b1;
        exp_q.push_back(e);
        n0 = valid_count;
        @(negedge clock);
        start  = 1'b0;
        bin_in = ~v;
        wait_valid(n0, name);
        @(negedge clock);
        check({name, "_ready_after"}, 32'(ready), 32'd1);
        check({name, "_valid_one_cycle"}, 32'(valid), 32'd0);
    endtask

    initial begin
        int n0;
        #3;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_bcd", 32'(bcd_out), 32'h000);
        @(negedge clock);
        reset = 1'b1;

        // Directed vectors, hand-computed
        convert(8'd0,   12'h000, "zero");
        check("zero_hold_bcd", 32'(bcd_out), 32'h000);
        convert(8'd55,  12'h055, "fib10");
        convert(8'd233, 12'h233, "fib13");
        convert(8'd255, 12'h255, "max");
        check("max_hold_bcd", 32'(bcd_out), 32'h255);
        convert(8'd9,   12'h009, "nine");
        convert(8'd10,  12'h010, "ten");
        convert(8'd100, 12'h100, "hundred");

        // Full sweep against a decimal reference
        for (int v = 0; v < 256; v++) convert(8'(v), to_bcd(v), "sweep");

        // Start pulses during SHIFT and DONE are ignored
        @(negedge clock);
        n0 = valid_count;
        bin_in = 8'd89;
        start  = 1'b1;
        exp_q.push_back(12'h089);
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        bin_in = 8'd13;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 40 && !valid; i++) @(negedge clock);
        check("ignore_reached_done", 32'(valid), 32'd1);
        start  = 1'b1;
        bin_in = 8'd13;
        @(negedge clock);
        start = 1'b0;
        repeat (20) @(negedge clock);
        check("ignore_one_pulse", 32'(valid_count - n0), 32'd1);
        check("ignore_bcd", 32'(bcd_out), 32'h089);

        // Reset at the 4th SHIFT edge of a 144 conversion
        @(negedge clock);
        n0 = valid_count;
        bin_in = 8'd144;
        start  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_bcd", 32'(bcd_out), 32'h000);
        @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        check("abort_no_valid", 32'(valid_count - n0), 32'd0);
        convert(8'd144, 12'h144, "after_reset");

        // Start held high: back-to-back conversions 10 cycles apart
        @(negedge clock);
        n0 = valid_count;
        bin_in = 8'd21;
        start  = 1'b1;
        exp_q.push_back(12'h021);
        @(negedge clock);
        bin_in = 8'd34;
        exp_q.push_back(12'h034);
        for (int i = 0; i < 40 && !ready; i++) @(negedge clock);
        @(negedge clock);
        start  = 1'b0;
        bin_in = 8'd0;
        repeat (20) @(negedge clock);
        check("b2b_pulses", 32'(valid_count - n0), 32'd2);
        check("b2b_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'd10);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete (got timeout expected finish)");
        $fatal(1);
    end

endmodule
